// File: rtl/lru_replace_responder_pkg.sv
// lru_replace_responder_pkg: cache geometry, FSM encoding, age-row type and reset row for the LRU responder
package lru_replace_responder_pkg;
    localparam int WAY = 4;
    localparam int BLOCK_SIZE_BYTE = 16;
    localparam int CACHE_SIZE_BYTE = 32 * 1024;
    localparam int BLOCK_OFFSET_INDEX = $clog2(BLOCK_SIZE_BYTE);
    localparam int SET = CACHE_SIZE_BYTE / ((1 << BLOCK_OFFSET_INDEX) * WAY);
    localparam int SET_INDEX = $clog2(SET);
    localparam int AW = $clog2(WAY);
    localparam int WAY_W = 5;
    typedef enum logic [2:0] {INIT, IDLE, SCAN, GRANT, WAIT} state_t;
    typedef logic [WAY-1:0][AW-1:0] age_row_t;
    function automatic age_row_t init_row();
        age_row_t r;
        for (int w = 0; w < WAY; w++) r[w] = AW'(w);
        return r;
    endfunction
endpackage

// File: rtl/lru_age_update.sv
// lru_age_update: combinational true-LRU touch; makes way_sel MRU and ages every way that was younger
// ports: row (current ages), way_sel (touched way), updated (new ages)
module lru_age_update
    import lru_replace_responder_pkg::*;
(
    input  age_row_t      row,
    input  logic [AW-1:0] way_sel,
    output age_row_t      updated
);
    always_comb begin
        updated = row;
        for (int w = 0; w < WAY; w++)
            updated[w] = (AW'(w) == way_sel) ? '0 : (row[w] < row[way_sel]) ? row[w] + AW'(1) : row[w];
    end
endmodule

// File: rtl/lru_replace_responder.sv
// lru_replace_responder: per-set true-LRU state, victim scan and one-cycle grant on the replace handshake
// ports: clk/rst_n (sync active-low), index, access_valid/access_way (hit/fill touch),
//        replace (held request), block_replace/replace_way (grant), busy, replace_count, pending_overflow
module lru_replace_responder
    import lru_replace_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SET_INDEX-1:0] index,
    input  logic                 access_valid,
    input  logic [WAY_W-1:0]     access_way,
    input  logic                 replace,
    output logic                 block_replace,
    output logic [WAY_W-1:0]     replace_way,
    output logic                 busy,
    output logic [31:0]          replace_count,
    output logic                 pending_overflow
);
    state_t state, state_n;
    age_row_t ages [SET];
    age_row_t touch_row;
    logic [SET_INDEX-1:0] set_cnt, lat_set, pend_set, touch_set;
    logic [AW-1:0] scan_w, best_way, best_age, pend_way, touch_way, acc_way;
    logic pend_valid, touch_en, acc_ok, pend_load;

    assign acc_way = access_way[AW-1:0];
    assign acc_ok = access_valid && (access_way < WAY_W'(WAY));
    // accesses arriving while a replace is in flight are parked in a one-entry slot
    assign pend_load = acc_ok && (state == SCAN || state == GRANT || state == WAIT);
    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        touch_en = 1'b0;
        touch_set = index;
        touch_way = acc_way;
        case (state)
            INIT: state_n = (set_cnt == SET_INDEX'(SET - 1)) ? IDLE : INIT;
            IDLE: begin
                // a parked access wins over a new replace, which is retried next cycle
                if (pend_valid) begin
                    touch_en = 1'b1;
                    touch_set = pend_set;
                    touch_way = pend_way;
                end else if (replace) begin
                    state_n = SCAN;
                end else begin
                    touch_en = acc_ok;
                end
            end
            SCAN: state_n = (scan_w == AW'(WAY - 1)) ? GRANT : SCAN;
            GRANT: begin
                touch_en = 1'b1;
                touch_set = lat_set;
                touch_way = best_way;
                state_n = WAIT;
            end
            WAIT: state_n = replace ? WAIT : IDLE;
            default: state_n = INIT;
        endcase
    end

    lru_age_update u_upd (
        .row(ages[touch_set]),
        .way_sel(touch_way),
        .updated(touch_row)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            set_cnt <= '0;
            lat_set <= '0;
            scan_w <= '0;
            best_age <= '0;
            best_way <= '0;
            pend_valid <= 1'b0;
            pend_set <= '0;
            pend_way <= '0;
            block_replace <= 1'b0;
            replace_way <= '0;
            replace_count <= '0;
            pending_overflow <= 1'b0;
        end else begin
            state <= state_n;
            block_replace <= state == GRANT;
            if (state == INIT) set_cnt <= set_cnt + SET_INDEX'(1);
            if (state == IDLE && !pend_valid && replace) begin
                lat_set <= index;
                scan_w <= '0;
                best_age <= '0;
                best_way <= '0;
            end
            if (state == SCAN) begin
                // strict compare keeps the lower way on ties
                if (ages[lat_set][scan_w] > best_age) begin
                    best_age <= ages[lat_set][scan_w];
                    best_way <= scan_w;
                end
                scan_w <= scan_w + AW'(1);
            end
            if (state == GRANT) begin
                replace_way <= WAY_W'(best_way);
                replace_count <= replace_count + 32'd1;
            end
            if (state == IDLE && pend_valid) pend_valid <= 1'b0;
            if (pend_load) begin
                pend_valid <= 1'b1;
                pend_set <= index;
                pend_way <= acc_way;
                if (pend_valid) pending_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT) ages[set_cnt] <= init_row();
            else if (touch_en) ages[touch_set] <= touch_row;
        end
    end
endmodule

// File: tb/tb_lru_replace_responder.sv
// tb_lru_replace_responder: directed self-checking bench for the LRU replace responder
module tb_lru_replace_responder;
    import lru_replace_responder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [SET_INDEX-1:0] index = '0;
    logic access_valid = 1'b0;
    logic [WAY_W-1:0] access_way = '0;
    logic replace = 1'b0;
    logic block_replace;
    logic [WAY_W-1:0] replace_way;
    logic busy;
    logic [31:0] replace_count;
    logic pending_overflow;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lru_replace_responder dut (
        .clk(clk),
        .rst_n(rst_n),
        .index(index),
        .access_valid(access_valid),
        .access_way(access_way),
        .replace(replace),
        .block_replace(block_replace),
        .replace_way(replace_way),
        .busy(busy),
        .replace_count(replace_count),
        .pending_overflow(pending_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output int lat);
        lat = 0;
        while (block_replace !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic request(input int idx, output int lat);
        index = SET_INDEX'(idx);
        replace = 1'b1;
        wait_grant(lat);
    endtask

    task automatic release_req();
        replace = 1'b0;
        tick();
    endtask

    task automatic touch(input int idx, input int w);
        index = SET_INDEX'(idx);
        access_way = WAY_W'(w);
        access_valid = 1'b1;
        tick();
        access_valid = 1'b0;
    endtask

    initial begin
        int lat, n, extra;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 1);
        chk("rst_block_replace", 32'(block_replace), 0);
        chk("rst_replace_way", 32'(replace_way), 0);
        chk("rst_replace_count", replace_count, 0);
        chk("rst_overflow", 32'(pending_overflow), 0);

        rst_n = 1'b1;
        wait_init(n);
        chk("init_cycles", 32'(n), 512);

        request(3, lat);
        chk("idx3_latency", 32'(lat), 6);
        chk("idx3_way", 32'(replace_way), 3);
        chk("idx3_count", replace_count, 1);
        release_req();
        chk("strobe_one_cycle", 32'(block_replace), 0);
        chk("idle_not_busy", 32'(busy), 0);

        touch(7, 3);
        touch(7, 2);
        touch(7, 1);
        touch(7, 0);
        request(7, lat);
        chk("idx7_way_a", 32'(replace_way), 3);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (block_replace === 1'b1) extra++;
        end
        chk("held_no_regrant", 32'(extra), 0);
        chk("held_busy", 32'(busy), 1);
        chk("held_way_holds", 32'(replace_way), 3);
        release_req();
        request(7, lat);
        chk("idx7_way_b", 32'(replace_way), 2);
        chk("idx7_count_b", replace_count, 3);
        release_req();
        touch(7, 3);
        request(7, lat);
        chk("idx7_way_c", 32'(replace_way), 1);
        release_req();

        index = SET_INDEX'(9);
        replace = 1'b1;
        tick();
        touch(9, 3);
        wait_grant(lat);
        chk("idx9_latency", 32'(lat + 2), 6);
        chk("idx9_way", 32'(replace_way), 3);
        release_req();
        request(9, lat);
        chk("pending_first_latency", 32'(lat), 7);
        chk("idx9_way_later", 32'(replace_way), 2);
        chk("no_overflow", 32'(pending_overflow), 0);
        release_req();

        index = SET_INDEX'(13);
        replace = 1'b1;
        tick();
        index = SET_INDEX'(14);
        access_way = WAY_W'(3);
        access_valid = 1'b1;
        tick();
        index = SET_INDEX'(15);
        tick();
        access_valid = 1'b0;
        wait_grant(lat);
        chk("idx13_latency", 32'(lat + 3), 6);
        chk("idx13_way", 32'(replace_way), 3);
        chk("overflow_set", 32'(pending_overflow), 1);
        release_req();
        tick();
        request(14, lat);
        chk("overwritten_touch", 32'(replace_way), 3);
        release_req();
        request(15, lat);
        chk("surviving_touch", 32'(replace_way), 2);
        release_req();

        touch(20, 7);
        request(20, lat);
        chk("bad_way_ignored", 32'(replace_way), 3);
        chk("count_before_reset", replace_count, 10);
        release_req();

        index = SET_INDEX'(7);
        replace = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_grant_no_strobe", 32'(block_replace), 0);
        rst_n = 1'b0;
        replace = 1'b0;
        tick();
        chk("grant_rst_strobe", 32'(block_replace), 0);
        chk("grant_rst_busy", 32'(busy), 1);
        chk("grant_rst_count", replace_count, 0);
        chk("grant_rst_way", 32'(replace_way), 0);
        chk("grant_rst_overflow", 32'(pending_overflow), 0);
        rst_n = 1'b1;
        wait_init(n);
        chk("reinit_cycles", 32'(n), 512);
        request(7, lat);
        chk("reinit_latency", 32'(lat), 6);
        chk("reinit_way", 32'(replace_way), 3);
        chk("reinit_count", replace_count, 1);
        release_req();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
